// File: rtl/gb_int_pkg.sv
// Shared constants, state encoding and vector helper for the Game Boy interrupt controller.
package gb_int_pkg;

  localparam int unsigned NUM_IRQ = 5;
  localparam int unsigned SEL_W   = 3;

  localparam int unsigned INT_VBLANK = 0;
  localparam int unsigned INT_STAT   = 1;
  localparam int unsigned INT_TIMER  = 2;
  localparam int unsigned INT_SERIAL = 3;
  localparam int unsigned INT_JOYPAD = 4;

  localparam logic [15:0] IF_ADDR  = 16'hFF0F;
  localparam logic [15:0] IE_ADDR  = 16'hFFFF;
  localparam logic [7:0]  VEC_BASE = 8'h40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Vectors are spaced 8 bytes apart starting at VEC_BASE.
  function automatic logic [7:0] vec_of(input logic [SEL_W-1:0] sel);
    return VEC_BASE + 8'({sel, 3'b000});
  endfunction

endpackage

// File: rtl/gb_int_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest-priority interrupt source.
module gb_int_prio_enc
  import gb_int_pkg::*;
(
  input  logic [NUM_IRQ-1:0] pending,
  output logic [SEL_W-1:0]   sel,
  output logic               valid
);

  // Scan downwards so the lowest set bit is the last to overwrite sel.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel   = SEL_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME sequencing, priority
// arbitration and the request/acknowledge handshake with the CPU core.
module gb_interrupt_ctrl
  import gb_int_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [15:0]        A_cpu,
  input  logic [7:0]         Di_cpu,
  input  logic               wr_cpu,
  input  logic               ei_req,
  input  logic               di_req,
  input  logic               reti_req,
  input  logic               instr_done,
  input  logic               int_ack,
  output logic [7:0]         IF,
  output logic [7:0]         IE,
  output logic               int_req,
  output logic [7:0]         int_vector,
  output logic               halt_wake,
  output logic               ime
);

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] if_q, if_n;
  logic [7:0]         ie_q, ie_n;
  logic [NUM_IRQ-1:0] src_prev;
  logic               ime_pending, ime_pending_n, ime_n;
  logic               int_req_n;
  logic [7:0]         int_vector_n;

  logic [NUM_IRQ-1:0] pending, src_edge, ack_mask;
  logic [SEL_W-1:0]   sel;
  logic               valid, ack_take, wr_if, wr_ie;

  gb_int_prio_enc u_prio_enc (
    .pending (pending),
    .sel     (sel),
    .valid   (valid)
  );

  assign pending   = ie_q[NUM_IRQ-1:0] & if_q;
  assign src_edge  = irq_src & ~src_prev;
  assign wr_if     = wr_cpu && (A_cpu == IF_ADDR);
  assign wr_ie     = wr_cpu && (A_cpu == IE_ADDR);
  assign ack_take  = (state == REQ) && int_ack && valid && ime;
  assign ack_mask  = ack_take ? (NUM_IRQ'(1) << sel) : '0;

  assign IF        = {3'b111, if_q};
  assign IE        = ie_q;
  assign halt_wake = |pending;

  // Next-state for FSM, IF/IE and IME; later assignments take precedence.
  always_comb begin
    state_n       = state;
    int_req_n     = int_req;
    int_vector_n  = int_vector;
    ime_n         = ime;
    ime_pending_n = ime_pending;
    ie_n          = wr_ie ? Di_cpu : ie_q;

    // Write replaces, ack clears, a fresh edge always sets.
    if_n = ((wr_if ? Di_cpu[NUM_IRQ-1:0] : if_q) & ~ack_mask) | src_edge;

    // ime_pending is the registered value, so a same-cycle instr_done is not counted.
    if (ime_pending && instr_done) begin
      ime_n         = 1'b1;
      ime_pending_n = 1'b0;
    end
    if (ei_req) ime_pending_n = 1'b1;
    if (reti_req) begin
      ime_n         = 1'b1;
      ime_pending_n = 1'b0;
    end
    if (ack_take || di_req) begin
      ime_n         = 1'b0;
      ime_pending_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (ime && valid) begin
          state_n      = REQ;
          int_req_n    = 1'b1;
          int_vector_n = vec_of(sel);
        end
      end
      REQ: begin
        if (!valid || !ime) begin
          state_n   = IDLE;
          int_req_n = 1'b0;
        end else begin
          int_vector_n = vec_of(sel);
          if (int_ack) begin
            state_n   = SERVICE;
            int_req_n = 1'b0;
          end
        end
      end
      SERVICE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      if_q        <= '0;
      ie_q        <= '0;
      src_prev    <= '0;
      ime         <= 1'b0;
      ime_pending <= 1'b0;
      int_req     <= 1'b0;
      int_vector  <= '0;
    end else begin
      state       <= state_n;
      if_q        <= if_n;
      ie_q        <= ie_n;
      src_prev    <= irq_src;
      ime         <= ime_n;
      ime_pending <= ime_pending_n;
      int_req     <= int_req_n;
      int_vector  <= int_vector_n;
    end
  end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Randomized and directed bench for gb_interrupt_ctrl against a behavioural model.
module tb_gb_interrupt_ctrl;

  logic        clock;
  logic        reset_n;
  logic [4:0]  irq_src;
  logic [15:0] A_cpu;
  logic [7:0]  Di_cpu;
  logic        wr_cpu, ei_req, di_req, reti_req, instr_done, int_ack;
  logic [7:0]  IF, IE, int_vector;
  logic        int_req, halt_wake, ime;

  gb_interrupt_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .A_cpu      (A_cpu),
    .Di_cpu     (Di_cpu),
    .wr_cpu     (wr_cpu),
    .ei_req     (ei_req),
    .di_req     (di_req),
    .reti_req   (reti_req),
    .instr_done (instr_done),
    .int_ack    (int_ack),
    .IF         (IF),
    .IE         (IE),
    .int_req    (int_req),
    .int_vector (int_vector),
    .halt_wake  (halt_wake),
    .ime        (ime)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per-source flags, phase 0=idle 1=requesting 2=servicing.
  bit       m_if[5];
  bit       m_prev[5];
  bit [7:0] m_ie;
  bit       m_ime, m_ei_wait, m_req;
  int       m_phase;
  int       m_vec;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_if[i]   = 0;
      m_prev[i] = 0;
    end
    m_ie = 0; m_ime = 0; m_ei_wait = 0; m_req = 0; m_phase = 0; m_vec = 0;
  endtask

  function automatic int m_top();
    for (int i = 0; i < 5; i++)
      if (m_ie[i] && m_if[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_if_byte();
    logic [7:0] b;
    b = 8'hE0;
    for (int i = 0; i < 5; i++) if (m_if[i]) b = b | (8'h01 << i);
    return b;
  endfunction

  function automatic bit m_wake();
    return m_top() >= 0;
  endfunction

  task automatic model_step();
    int  top;
    bit  acked;
    bit  ime_old;
    logic [7:0] di;
    top     = m_top();
    ime_old = m_ime;
    di      = Di_cpu;
    acked   = (m_phase == 1) && int_ack && (top >= 0) && ime_old;
    for (int i = 0; i < 5; i++) begin
      bit nb;
      nb = m_if[i];
      if (wr_cpu && A_cpu == 16'hFF0F) nb = di[i];
      if (acked && i == top) nb = 0;
      if (irq_src[i] && !m_prev[i]) nb = 1;
      m_if[i]   = nb;
      m_prev[i] = irq_src[i];
    end
    if (wr_cpu && A_cpu == 16'hFFFF) m_ie = Di_cpu;
    if (m_ei_wait && instr_done) begin m_ime = 1; m_ei_wait = 0; end
    if (ei_req) m_ei_wait = 1;
    if (reti_req) begin m_ime = 1; m_ei_wait = 0; end
    if (acked || di_req) begin m_ime = 0; m_ei_wait = 0; end
    case (m_phase)
      0: if (ime_old && top >= 0) begin m_phase = 1; m_req = 1; m_vec = 'h40 + 8 * top; end
      1: begin
        if (top < 0 || !ime_old) begin
          m_phase = 0; m_req = 0;
        end else begin
          m_vec = 'h40 + 8 * top;
          if (int_ack) begin m_phase = 2; m_req = 0; end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    check_eq("if",   16'(IF),         16'(m_if_byte()));
    check_eq("ie",   16'(IE),         16'(m_ie));
    check_eq("req",  16'(int_req),    16'(m_req));
    check_eq("vec",  16'(int_vector), 16'(m_vec));
    check_eq("wake", 16'(halt_wake),  16'(m_wake()));
    check_eq("ime",  16'(ime),        16'(m_ime));
  endtask

  task automatic clear_pulses();
    wr_cpu = 0; ei_req = 0; di_req = 0; reti_req = 0; instr_done = 0; int_ack = 0;
    A_cpu = 16'h0000; Di_cpu = 8'h00;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
    clear_pulses();
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_if",  16'(IF),         16'h00E0);
    check_eq("rst_ie",  16'(IE),         16'h0000);
    check_eq("rst_req", 16'(int_req),    16'h0000);
    check_eq("rst_vec", 16'(int_vector), 16'h0000);
    check_eq("rst_ime", 16'(ime),        16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_cpu = 1; A_cpu = a; Di_cpu = d;
    cycle();
  endtask

  task automatic enable_ime();
    ei_req = 1; cycle();
    instr_done = 1; cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    irq_src = '0;
    clear_pulses();
    model_reset();
    @(negedge clock);

    // 1: basic latency path
    do_reset();
    wr(16'hFFFF, 8'h1F);
    enable_ime();
    check_eq("t1_ime", 16'(ime), 16'h0001);
    irq_src = 5'b00100; cycle();
    check_eq("t1_if", 16'(IF), 16'h00E4);
    check_eq("t1_req0", 16'(int_req), 16'h0000);
    cycle();
    check_eq("t1_req", 16'(int_req), 16'h0001);
    check_eq("t1_vec", 16'(int_vector), 16'h0050);

    // 2: priority, ack and reti
    irq_src = '0;
    do_reset();
    wr(16'hFFFF, 8'h1F);
    enable_ime();
    irq_src = 5'b10001; cycle();
    cycle();
    check_eq("t2_vec", 16'(int_vector), 16'h0040);
    int_ack = 1; cycle();
    check_eq("t2_if", 16'(IF), 16'h00F0);
    check_eq("t2_ime", 16'(ime), 16'h0000);
    check_eq("t2_req", 16'(int_req), 16'h0000);
    reti_req = 1; cycle();
    cycle();
    check_eq("t2_req2", 16'(int_req), 16'h0001);
    check_eq("t2_vec2", 16'(int_vector), 16'h0060);

    // 3: disabled source, halt_wake follows IE
    irq_src = '0;
    do_reset();
    irq_src = 5'b00010; cycle();
    check_eq("t3_if", 16'(IF), 16'h00E2);
    check_eq("t3_wake0", 16'(halt_wake), 16'h0000);
    cycle();
    check_eq("t3_req", 16'(int_req), 16'h0000);
    wr(16'hFFFF, 8'h02);
    check_eq("t3_wake1", 16'(halt_wake), 16'h0001);

    // 4: set beats write
    irq_src = '0;
    do_reset();
    irq_src = 5'b01000;
    wr(16'hFF0F, 8'h00);
    check_eq("t4_if", 16'(IF), 16'h00E8);

    // 5: request withdrawn by clearing IF, late ack ignored
    irq_src = '0;
    do_reset();
    wr(16'hFFFF, 8'h1F);
    enable_ime();
    irq_src = 5'b01000; cycle();
    cycle();
    check_eq("t5_vec", 16'(int_vector), 16'h0058);
    wr(16'hFF0F, 8'h00);
    cycle();
    check_eq("t5_req", 16'(int_req), 16'h0000);
    int_ack = 1; cycle();
    check_eq("t5_if", 16'(IF), 16'h00E0);
    check_eq("t5_ime", 16'(ime), 16'h0001);

    // 6: reset during SERVICE, held source re-latches after release
    irq_src = '0;
    do_reset();
    wr(16'hFFFF, 8'h1F);
    enable_ime();
    irq_src = 5'b00001; cycle();
    cycle();
    int_ack = 1; cycle();
    do_reset();
    cycle();
    check_eq("t6_if", 16'(IF), 16'h00E1);

    // Randomized traffic against the model
    irq_src = '0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(7) == 0) irq_src[i] = ~irq_src[i];
      if ($urandom_range(5) == 0) begin
        wr_cpu = 1;
        case ($urandom_range(2))
          0: A_cpu = 16'hFF0F;
          1: A_cpu = 16'hFFFF;
          default: A_cpu = 16'($urandom);
        endcase
        Di_cpu = 8'($urandom);
      end
      ei_req     = ($urandom_range(9) == 0);
      di_req     = ($urandom_range(24) == 0);
      reti_req   = ($urandom_range(24) == 0);
      instr_done = ($urandom_range(2) == 0);
      int_ack    = m_req ? ($urandom_range(2) == 0) : ($urandom_range(29) == 0);
      cycle();
      if (n == 2000) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_interrupt_ctrl.md
Name: gb_interrupt_ctrl

Overview:
Game Boy interrupt controller. It owns the IF (FF0F) and IE (FFFF) registers and latches peripheral requests into IF. It also arbitrates pending interrupts by fixed priority and runs the dispatch handshake with the CPU core. It sits directly upstream of the CPU-internal address decoder: its IF and IE outputs are the register values that decoder returns for reads of FF0F and FFFF. It snoops the same CPU write bus for writes to those two addresses.

Parameters:
NUM_IRQ, 5, number of interrupt sources; bit 0 is the highest priority.
IF_ADDR, 16'hFF0F, CPU address of the IF register.
IE_ADDR, 16'hFFFF, CPU address of the IE register.
VEC_BASE, 8'h40, vector of source 0; each following source adds 8'h08.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
irq_src  in  NUM_IRQ  peripheral request levels: [0]=VBlank, [1]=STAT, [2]=Timer, [3]=Serial, [4]=Joypad.
A_cpu  in  16  CPU address.
Di_cpu  in  8  CPU write data.
wr_cpu  in  1  CPU write strobe, one cycle per access.
ei_req  in  1  pulse: CPU executed EI.
di_req  in  1  pulse: CPU executed DI.
reti_req  in  1  pulse: CPU executed RETI.
instr_done  in  1  pulse: CPU finished an instruction.
int_ack  in  1  pulse: CPU begins interrupt dispatch.
IF  out  8  {3'b111, if_q[4:0]}.
IE  out  8  full 8-bit IE storage.
int_req  out  1  registered: an interrupt is ready for dispatch.
int_vector  out  8  vector of the interrupt being requested or serviced.
halt_wake  out  1  combinational OR-reduction of (IE[4:0] & if_q); independent of IME.
ime  out  1  interrupt master enable.

Behaviour:
- Reset values (while reset_n=0, asynchronous):
  - if_q=0, so IF=8'hE0; IE=8'h00.
  - ime=0, ime_pending=0.
  - int_req=0, int_vector=8'h00, state=IDLE.
  - src_prev=0, so a source already high at reset release sets its IF bit one cycle later.
- Edge detection: edge = irq_src & ~src_prev; src_prev <= irq_src every cycle.
- IF next-state priority, lowest to highest:
  - base: current if_q;
  - CPU write to IF_ADDR: replace with Di_cpu[4:0];
  - ack clear: clear the bit of the latched serviced source;
  - set: OR in edge.
  - A set always wins over a write or ack clear in the same cycle.
- IE: a CPU write to IE_ADDR loads all 8 bits. Writes to any other address are ignored.
- pending = IE[4:0] & if_q; sel = index of the lowest set bit of pending.
- IME:
  - di_req clears ime and ime_pending immediately.
  - ei_req sets ime_pending; ime becomes 1 on the first instr_done after that (one-instruction EI delay). An instr_done in the same cycle as ei_req does not count.
  - reti_req sets ime immediately and clears ime_pending.
  - int_ack clears ime and ime_pending.
  - If di_req and ei_req arrive together, di wins.
- State machine (registered):
  - IDLE: if ime and pending!=0, go to REQ. On entry, int_req<=1 and int_vector<=VEC_BASE+8*sel.
  - REQ: int_vector tracks the current highest-priority pending source each cycle, so a higher-priority source preempts until ack.
    - If pending becomes 0 or ime drops, go to IDLE with int_req<=0.
    - On int_ack, latch sel as the serviced source, clear its IF bit, clear ime, set int_req<=0, hold int_vector, go to SERVICE.
  - SERVICE: return to IDLE after one cycle. int_vector holds its value until the next REQ entry.
- int_ack outside REQ is ignored: no IF clear, no IME change.
- Latency: a source edge at cycle N sets IF at N+1. With IME=1 and the bit enabled, int_req is high at N+2.
- halt_wake responds in the same cycle as the IF or IE update (from registered state), with no IME gating.

Decomposition:
- Shared package gb_int_pkg:
  - source index constants (INT_VBLANK=0 … INT_JOYPAD=4);
  - NUM_IRQ, IF_ADDR, IE_ADDR, VEC_BASE;
  - state enum {IDLE, REQ, SERVICE}.
- One natural sub-module: gb_int_prio_enc, a combinational lowest-set-bit encoder (pending → sel, valid). Everything else stays in the top.

Test Plan:
1. Reset → IF=E0, IE=00, ime=0, int_req=0. Then write FFFF=1F, pulse ei_req, then instr_done, raise irq_src[2] → IF=E4 one cycle after the edge, int_req=1 and int_vector=50 one cycle later.
2. IME=1, IE=1F, raise irq_src[4] and irq_src[0] together → int_vector=40. Pulse int_ack → IF=F0 (bit0 cleared), ime=0, int_req=0. Pulse reti_req → int_req=1, vector=60.
3. IE=00, irq_src[1] edge → int_req stays 0, IF=E2, halt_wake=0. Write FFFF=02 → halt_wake=1 in the same cycle as IE updates.
4. Write FF0F=00 in the same cycle as an irq_src[3] rising edge → IF=E8 (set wins).
5. In REQ with vector=58, write FF0F=00 before ack → int_req falls next cycle and the state returns to IDLE. An int_ack pulsed afterwards changes nothing.
6. Assert reset_n=0 mid-SERVICE → all outputs immediately take their reset values. src_prev=0, so a held irq_src[0]=1 sets IF=E1 one cycle after reset release.
